// File: rtl/udp_pkg.sv
// Shared UDP definitions for the TX header generator and the RX checker.
// Holds header constants, the control FSM state type, the registered
// request record and the checksum-field helper.
package udp_pkg;
  localparam int          UDP_HEAD_W      = 64;
  localparam int          UDP_HEAD_BYTES  = 8;
  localparam logic [7:0]  UDP_PROTO       = 8'h11;
  localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd65527;
  // pseudo-header + header + payload partial sum, one 16-bit word each
  localparam int          UDP_SUM_WORDS   = 10;

  typedef enum logic [1:0] {IDLE, SUM, SEND} udp_state_e;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] payload_sum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } udp_req_t;

  // A computed checksum of zero is sent as all-ones; 0000 on the wire
  // means "no checksum".
  function automatic logic [15:0] udp_csum_field(input logic [15:0] c);
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction
endpackage

// File: rtl/udp_csum_acc.sv
// 16-bit one's-complement accumulator.
// Ports: clk/reset (async, active-high); clr zeroes the sum; add folds
// word into the sum with end-around carry; sum_o is the folded running
// sum, csum_o its complement.
module udp_csum_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] sum_o,
  output logic [15:0] csum_o
);
  logic [15:0] acc;
  logic [16:0] add_raw;

  // carry out of the 17-bit add is wrapped back in every cycle, so the
  // stored value is always a fully folded 16-bit sum
  assign add_raw = {1'b0, acc} + {1'b0, word};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= add_raw[15:0] + {15'b0, add_raw[16]};
  end

  assign sum_o  = acc;
  assign csum_o = ~acc;
endmodule

// File: rtl/udp_head_tx_stream.sv
// Streaming UDP header generator (TX).
// Accepts one request per packet (req_valid_i/req_ready_o) carrying ports,
// payload length, IPv4 addresses and the payload partial sum. With HAS_CRC
// the checksum over pseudo-header+header+payload is built serially (10
// cycles). The 64-bit header {csum, udp_len, dst_port, src_port} is then
// sent LSB-first as DATA_W beats (head_valid_o/head_ready_i, head_last_o).
// len_err_o pulses when a request's payload would overflow udp_len.
// DATA_W must be 16, 32 or 64.
module udp_head_tx_stream
  import udp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int HAS_CRC = 0,
  parameter int PORT_W  = 16,
  parameter int LEN_W   = 16,
  parameter int IP_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [PORT_W-1:0] src_port_i,
  input  logic [PORT_W-1:0] dst_port_i,
  input  logic [LEN_W-1:0]  payload_len_i,
  input  logic [15:0]       payload_sum_i,
  input  logic [IP_W-1:0]   src_ip_i,
  input  logic [IP_W-1:0]   dst_ip_i,
  output logic              head_valid_o,
  input  logic              head_ready_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic              len_err_o
);
  localparam int NBEAT = UDP_HEAD_W / DATA_W;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  udp_state_e            state, state_nxt;
  udp_req_t              req_q;
  logic [3:0]            sum_cnt;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  len_err_q;
  logic                  accept, len_bad, take, beat_last, last_hs;
  logic [15:0]           sum_word, csum_field;
  logic [NBEAT-1:0][DATA_W-1:0] beats;

  assign accept    = req_valid_i && (state == IDLE);
  assign len_bad   = payload_len_i > LEN_W'(UDP_MAX_PAYLOAD);
  assign take      = accept && !len_bad;
  assign beat_last = beat_cnt == CNT_W'(NBEAT - 1);
  assign last_hs   = (state == SEND) && head_ready_i && beat_last;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = (HAS_CRC != 0) ? SUM : SEND;
      SUM:     if (sum_cnt == 4'(UDP_SUM_WORDS - 1)) state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request capture, sequencing counters, error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= '0;
      sum_cnt   <= '0;
      beat_cnt  <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= accept && len_bad;
      if (take) begin
        req_q.src_port    <= 16'(src_port_i);
        req_q.dst_port    <= 16'(dst_port_i);
        req_q.udp_len     <= 16'(payload_len_i) + 16'(UDP_HEAD_BYTES);
        req_q.payload_sum <= payload_sum_i;
        req_q.src_ip      <= 32'(src_ip_i);
        req_q.dst_ip      <= 32'(dst_ip_i);
      end
      if (state == SUM && state_nxt == SUM) sum_cnt <= sum_cnt + 4'd1;
      else                                  sum_cnt <= '0;
      if (state == SEND && head_ready_i)
        beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // serial checksum word order: pseudo-header, UDP header, payload sum
  always_comb begin
    sum_word = '0;
    case (sum_cnt)
      4'd0:    sum_word = req_q.src_ip[31:16];
      4'd1:    sum_word = req_q.src_ip[15:0];
      4'd2:    sum_word = req_q.dst_ip[31:16];
      4'd3:    sum_word = req_q.dst_ip[15:0];
      4'd4:    sum_word = {8'h00, UDP_PROTO};
      4'd5:    sum_word = req_q.udp_len;
      4'd6:    sum_word = req_q.src_port;
      4'd7:    sum_word = req_q.dst_port;
      4'd8:    sum_word = req_q.udp_len;
      4'd9:    sum_word = req_q.payload_sum;
      default: sum_word = '0;
    endcase
  end

  generate
    if (HAS_CRC != 0) begin : g_crc
      logic [15:0] acc_csum, acc_sum_unused;
      // the last word lands on the SUM->SEND edge, so in SEND the
      // accumulator already holds the final sum
      udp_csum_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (take),
        .add    (state == SUM),
        .word   (sum_word),
        .sum_o  (acc_sum_unused),
        .csum_o (acc_csum)
      );
      assign csum_field = udp_csum_field(acc_csum);
    end else begin : g_nocrc
      logic unused_crc;
      assign unused_crc = ^sum_word;
      assign csum_field = 16'h0000;
    end
  endgenerate

  assign beats = {csum_field, req_q.udp_len, req_q.dst_port, req_q.src_port};

  // outputs decode registered state only; data/last hold while stalled
  // because beat_cnt only moves on head_ready_i
  always_comb begin
    req_ready_o  = (state == IDLE);
    head_valid_o = (state == SEND);
    head_last_o  = (state == SEND) && beat_last;
    head_data_o  = (state == SEND) ? beats[beat_cnt] : '0;
  end

  assign len_err_o = len_err_q;
endmodule

// File: tb/tb_udp_head_tx_stream.sv
module tb_udp_head_tx_stream;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] sp = '0, dp = '0, plen = '0, psum = '0;
  logic [31:0] sip = '0, dip = '0;
  // dut1: HAS_CRC=1, DATA_W=16 ; dut0: HAS_CRC=0, DATA_W=64
  logic        rdy1, hv1, hl1, le1, hr1 = 1'b1;
  logic        rdy0, hv0, hl0, le0, hr0 = 1'b1;
  logic [15:0] hd1;
  logic [63:0] hd0;

  typedef struct { logic [63:0] data; logic last; } beat_t;
  beat_t q1[$], q0[$];
  int    st1[$], st0[$];
  int    n_tests = 0, n_fail = 0, cyc = 0, t_acc = 0;
  int    rmode = 0;       // 0: ready high, 1: random, 2: stall beat 1 of dut1
  logic  pk1 = 0, pk0 = 0;
  int    bidx1 = 0, stall1 = 0;

  udp_head_tx_stream #(.DATA_W(16), .HAS_CRC(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .src_port_i(sp), .dst_port_i(dp), .payload_len_i(plen), .payload_sum_i(psum),
    .src_ip_i(sip), .dst_ip_i(dip), .head_valid_o(hv1), .head_ready_i(hr1),
    .head_data_o(hd1), .head_last_o(hl1), .len_err_o(le1));

  udp_head_tx_stream #(.DATA_W(64), .HAS_CRC(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy0),
    .src_port_i(sp), .dst_port_i(dp), .payload_len_i(plen), .payload_sum_i(psum),
    .src_ip_i(sip), .dst_ip_i(dip), .head_valid_o(hv0), .head_ready_i(hr0),
    .head_data_o(hd0), .head_last_o(hl0), .len_err_o(le0));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // reference: one's-complement sum of the ten checksum words, plain arithmetic
  function automatic logic [15:0] fold_sum(input logic [31:0] a, b,
      input logic [15:0] s, d, ulen, ps);
    longint t;
    t = a[31:16] + a[15:0] + b[31:16] + b[15:0] + 17 + ulen + s + d + ulen + ps;
    while (t > 65535) t = (t & 65535) + (t >> 16);
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_csum(input logic [31:0] a, b,
      input logic [15:0] s, d, ulen, ps);
    logic [15:0] c;
    c = ~fold_sum(a, b, s, d, ulen, ps);
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction

  task automatic send(input logic [15:0] s, d, l, ps, input logic [31:0] a, b);
    int n;
    logic bad;
    logic [15:0] ulen;
    logic [63:0] h1;
    beat_t bt;
    n = 0;
    @(negedge clk);
    while (!(rdy1 && rdy0) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin flag("accept_timeout"); return; end
    sp = s; dp = d; plen = l; psum = ps; sip = a; dip = b; req_valid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc - 1;
    bad  = l > 16'd65527;
    ulen = l + 16'd8;
    if (!bad) begin
      h1 = {ref_csum(a, b, s, d, ulen, ps), ulen, d, s};
      for (int k = 0; k < 4; k++) begin
        bt.data = {48'h0, h1[k*16 +: 16]}; bt.last = (k == 3); q1.push_back(bt);
      end
      bt.data = {16'h0000, ulen, d, s}; bt.last = 1'b1; q0.push_back(bt);
      st1.push_back(t_acc + 11);
      st0.push_back(t_acc + 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    // fields are don't-care once accepted
    sp = 16'($urandom); dp = 16'($urandom); plen = 16'($urandom); psum = 16'($urandom);
    sip = $urandom; dip = $urandom;
    chk("len_err1_pulse", le1, bad);
    chk("len_err0_pulse", le0, bad);
    @(negedge clk);
    chk("len_err1_clear", le1, 1'b0);
    chk("len_err0_clear", le0, 1'b0);
  endtask

  // monitor / ready driver for dut1
  initial begin : mon1
    logic r, lst;
    forever begin
      @(negedge clk);
      if (reset) begin pk1 = 0; hr1 = 1'b1; end
      else begin
        if (hv1 && !pk1) begin
          pk1 = 1; bidx1 = 0; stall1 = 3;
          if (st1.size() == 0) flag("start1_unexpected");
          else chk("start1_cycle", cyc, st1.pop_front());
        end
        if (rmode == 0) r = 1'b1;
        else if (rmode == 1) r = ($urandom_range(0, 3) != 0);
        else begin
          r = 1'b1;
          if (hv1 && bidx1 == 1 && stall1 > 0) begin r = 1'b0; stall1--; end
        end
        if (hv1) begin
          if (q1.size() == 0) flag("extra_beat1");
          else begin
            chk("data1", hd1, q1[0].data[15:0]);
            chk("last1", hl1, q1[0].last);
            chk("req_ready1_busy", rdy1, 1'b0);
            if (r) begin
              lst = q1[0].last; void'(q1.pop_front()); bidx1++;
              if (lst) pk1 = 0;
            end
          end
        end
        hr1 = r;
      end
    end
  end

  // monitor / ready driver for dut0
  initial begin : mon0
    logic r;
    forever begin
      @(negedge clk);
      if (reset) begin pk0 = 0; hr0 = 1'b1; end
      else begin
        if (hv0 && !pk0) begin
          pk0 = 1;
          if (st0.size() == 0) flag("start0_unexpected");
          else chk("start0_cycle", cyc, st0.pop_front());
        end
        r = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (hv0) begin
          if (q0.size() == 0) flag("extra_beat0");
          else begin
            chk("data0", hd0, q0[0].data);
            chk("last0", hl0, q0[0].last);
            if (r) begin void'(q0.pop_front()); pk0 = 0; end
          end
        end
        hr0 = r;
      end
    end
  end

  initial begin : main
    int n;
    logic [15:0] z;
    logic [15:0] rl;
    #12;
    chk("rst_ready1", rdy1, 1'b1); chk("rst_valid1", hv1, 1'b0);
    chk("rst_data1", hd1, 16'h0);  chk("rst_last1", hl1, 1'b0); chk("rst_err1", le1, 1'b0);
    chk("rst_ready0", rdy0, 1'b1); chk("rst_valid0", hv0, 1'b0);
    chk("rst_data0", hd0, 64'h0);  chk("rst_last0", hl0, 1'b0); chk("rst_err0", le0, 1'b0);
    @(posedge clk); #2 reset = 1'b0;

    // reference request
    rmode = 0;
    send(16'd18170, 16'd18170, 16'd4, 16'h1234, 32'hC0A80001, 32'hC0A800C7);
    // backpressure on beat 1
    rmode = 2;
    send(16'd18170, 16'd18170, 16'd4, 16'h1234, 32'hC0A80001, 32'hC0A800C7);
    rmode = 0;
    // length boundaries
    send(16'h1111, 16'h2222, 16'd65528, 16'h0F0F, 32'h0A000001, 32'h0A000002);
    send(16'h1111, 16'h2222, 16'd65527, 16'h0F0F, 32'h0A000001, 32'h0A000002);
    send(16'h3333, 16'h4444, 16'hFFFF,  16'h0000, 32'h0A000003, 32'h0A000004);
    // checksum that complements to zero
    z = fold_sum(32'h0A0B0C0D, 32'h01020304, 16'h5555, 16'h0035, 16'd108, 16'h0000);
    send(16'h5555, 16'h0035, 16'd100, ~z, 32'h0A0B0C0D, 32'h01020304);

    // reset during beat 2 of dut1's SEND
    send(16'hABCD, 16'h0050, 16'd20, 16'h7777, 32'hC0000201, 32'hC6336401);
    while (cyc < t_acc + 13) @(posedge clk);
    #2;
    chk("pre_reset_valid1", hv1, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid1", hv1, 1'b0); chk("mid_rst_data1", hd1, 16'h0);
    chk("mid_rst_last1", hl1, 1'b0);  chk("mid_rst_ready1", rdy1, 1'b1);
    chk("mid_rst_valid0", hv0, 1'b0);
    q1.delete(); q0.delete(); st1.delete(); st0.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    send(16'h0102, 16'h0304, 16'd33, 16'hBEEF, 32'h0B0C0D0E, 32'h0F101112);

    // randomized traffic with random backpressure
    rmode = 1;
    for (int i = 0; i < 30; i++) begin
      rl = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(65520, 65535))
                                       : 16'($urandom_range(0, 1500));
      send(16'($urandom), 16'($urandom), rl, 16'($urandom), $urandom, $urandom);
    end

    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    chk("drain1", q1.size(), 0);
    chk("drain0", q0.size(), 0);
    chk("starts1_left", st1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_head_tx_stream.md
# udp_head_tx_stream

Streaming UDP header generator for the TX path. It accepts one header request per packet over a valid/ready handshake, carrying run-time ports, payload length, IPv4 addresses and the payload's one's-complement partial sum. When enabled, it computes the full UDP checksum, including the pseudo-header, serially. It then emits the 64-bit header LSB-first as DATA_W-wide beats to the IPv4/MAC framing stage.

## Interface
- DATA_W, 16, output beat width; must be 16, 32 or 64.
- HAS_CRC, 0, 1 computes the checksum; 0 sends checksum field 16'h0000 (permitted by IPv4).
- PORT_W, 16, UDP port width.
- LEN_W, 16, UDP length width.
- IP_W, 32, IPv4 address width.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid_i  in  1  header request valid.
- req_ready_o  out  1  block can accept a request.
- src_port_i  in  PORT_W  source port.
- dst_port_i  in  PORT_W  destination port.
- payload_len_i  in  LEN_W  payload bytes, excluding the 8-byte header.
- payload_sum_i  in  16  folded one's-complement sum of the payload (odd byte zero-padded).
- src_ip_i  in  IP_W  IPv4 source address.
- dst_ip_i  in  IP_W  IPv4 destination address.
- head_valid_o  out  1  header beat valid.
- head_ready_i  in  1  downstream accepts beat.
- head_data_o  out  DATA_W  header beat.
- head_last_o  out  1  final beat of header.
- len_err_o  out  1  one-cycle pulse: request rejected for length overflow.

## Operation
- Header word: {csum[15:0], udp_len[15:0], dst_port, src_port}, with src_port in bits [15:0]. Beat k carries bits [k*DATA_W +: DATA_W]. NBEAT = 64/DATA_W.
- udp_len = payload_len_i + 8.
- Request fields are registered on acceptance (req_valid_i && req_ready_o). Inputs are don't-care afterwards.
- FSM states:
  - IDLE: req_ready_o=1. Accept moves to SUM if HAS_CRC, otherwise to SEND.
  - SUM: adds one 16-bit word per cycle into a 17-bit accumulator with end-around carry, over 10 cycles. Word order: src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 16'h0011, udp_len, src_port, dst_port, udp_len, payload_sum_i.
  - Leaving SUM: csum = ~sum. If that equals 16'h0000, send 16'hFFFF instead.
  - SEND: head_valid_o=1 and beat counter starts at 0. The counter advances on head_ready_i. head_last_o=1 when counter = NBEAT-1. Handshake on last beat returns to IDLE.
- Length overflow: payload_len_i > 65527 at acceptance raises len_err_o for one cycle, emits no header, and stays in IDLE.
- head_data_o and head_last_o hold stable while head_valid_o && !head_ready_i.
- No new request is accepted until the last beat handshakes (req_ready_o=0 in SUM/SEND).

## Timing
- Reset values: req_ready_o=1, head_valid_o=0, head_data_o=0, head_last_o=0, len_err_o=0. FSM in IDLE, counters and accumulator 0.
- Accept at cycle T:
  - First beat valid at T+1 (HAS_CRC=0) or T+11 (HAS_CRC=1).
  - With head_ready_i held high, the last beat is at first+NBEAT-1.
  - req_ready_o returns at the cycle after the last handshake.
- len_err_o is asserted at T+1.
- Reset asserted mid-SUM or mid-SEND: outputs go to reset values immediately. No partial header resumes after reset release.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package udp_pkg:
  - UDP_HEAD_W=64, UDP_HEAD_BYTES=8, UDP_PROTO=8'h11, UDP_MAX_PAYLOAD=16'd65527.
  - FSM state enum {IDLE, SUM, SEND}.
- Sub-module udp_csum_acc: 16-bit one's-complement accumulator with clear/add/fold/complement. It is reused by the RX checker.
- Generate HAS_CRC=0 without the accumulator instance.

## Test plan
- HAS_CRC=1, DATA_W=16, src_ip C0A80001, dst_ip C0A800C7, ports 18170/18170, len 4, payload_sum 1234 -> beats 46FA, 46FA, 000C, DD94 starting T+11; head_last_o on 4th.
- HAS_CRC=0, DATA_W=64, same request -> single beat 0000_000C_46FA_46FA at T+1, head_last_o=1.
- Backpressure: head_ready_i low 3 cycles on beat 1 -> beat 1 data held stable, no beat skipped or duplicated, req_ready_o stays 0.
- payload_len_i=65528 -> len_err_o pulse at T+1, head_valid_o never asserts. payload_len 65527 -> udp_len FFFF emitted.
- Checksum zero case: payload_sum chosen so ~sum=0000 -> field emitted as FFFF.
- Reset asserted during beat 2 of SEND -> head_valid_o=0 same cycle. After release, a new request produces a full correct header.
